effects_gain_sequencer: RTL and testbench
=========================================

Name: effects_gain_sequencer

Overview:
- Controller that sits in front of the effects pipeline.
- Turns the ADC per-sample tick into the pipeline `valid` strobe.
- Sequences the overdrive gain parameter so that it changes only on sample boundaries, ramping in fixed steps (no zipper noise).
- Provides a soft mute, and flags when the pipeline output is primed (first PIPE_LAT samples after reset discarded).

Parameters:
- GAIN_W, 11, width of the gain word (4 fractional bits, matching the pipeline gain input)
- STEP, 1, gain LSBs added/subtracted per sample tick while ramping
- PIPE_LAT, 3, number of valid strobes before the pipeline output is meaningful
- MUTE_GAIN, 0, gain value held while muted

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- i_sample_tick  in  1  one-cycle pulse per audio sample from the ADC interface
- i_gain_target  in  GAIN_W  requested gain from the user-control logic
- i_gain_load  in  1  one-cycle pulse: latch i_gain_target as the new target
- i_mute  in  1  level: 1 = request soft mute
- o_valid  out  1  pipeline valid strobe
- o_par_gain  out  GAIN_W  gain driven to the pipeline
- o_out_valid  out  1  pipeline output sample valid and primed
- o_busy  out  1  gain ramp in progress
- o_muted  out  1  gain held at MUTE_GAIN

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-low. All state is sampled on the rising edge of clk.
- Reset (rst=0 at an edge) forces:
  - o_valid=0, o_out_valid=0, o_busy=0, o_muted=0
  - o_par_gain=0, target register=0, prime counter=0, state=IDLE
- Reset mid-ramp or mid-mute abandons the operation immediately; no partial state survives.
- o_valid: registered copy of i_sample_tick, so exactly 1 cycle of latency. It is asserted for every tick, in every state.
- Gain update timing: o_par_gain changes only on the same edge that asserts o_valid. Between ticks it is stable.
- i_gain_load: latches i_gain_target into the target register on any cycle.
  - If the load coincides with a tick, that tick steps toward the OLD target; the new target applies from the next tick.
- Prime counter: saturating, counts o_valid pulses up to PIPE_LAT.
  - o_out_valid = o_valid AND (count already equal to PIPE_LAT before this pulse).
  - First o_out_valid therefore appears on valid pulse PIPE_LAT+1 after reset.
- State IDLE (gain == target, not muted):
  - Target != gain at a tick → RAMP, and the first step is applied on that same tick.
  - i_mute=1 at a tick → MUTE_DOWN; a step toward MUTE_GAIN is applied on that tick.
- State RAMP:
  - Each tick moves the gain by STEP toward the target.
  - The step is clamped so the gain never overshoots; reaching the target exactly → IDLE.
  - The target changing mid-ramp redirects the ramp (direction may reverse).
  - i_mute=1 at a tick takes priority → MUTE_DOWN.
- State MUTE_DOWN:
  - Steps toward MUTE_GAIN each tick, clamped; reaching it → MUTED.
  - i_mute dropping before MUTED → RAMP toward the target.
- State MUTED:
  - o_muted=1 and gain held at MUTE_GAIN; ticks still produce o_valid.
  - i_mute=0 at a tick → RAMP toward the target; a step is applied on that tick.
- o_busy = 1 in RAMP or MUTE_DOWN.
- Arithmetic:
  - Unsigned GAIN_W math; compute the difference at GAIN_W+1 bits.
  - Step = min(STEP, |target − gain|).
  - No wrap-around at 0 or at 2^GAIN_W−1; a target of all-ones ramps up and stops there.
- Transitions are evaluated only on tick cycles. Non-tick cycles hold all state except the target register.

Optional Feature:
- Macro: GAIN_SEQ_FAST_RAMP_EN.
- Defined: when |target − gain| > 16*STEP at a tick, the step used is 16*STEP; otherwise STEP. Clamping and no-overshoot rules still apply. Applies to RAMP and MUTE_DOWN.
- Undefined: the step is always STEP; there is no fast-step logic.

Test Plan:
- Reset/prime: hold rst=0 for 4 cycles, release, then 5 ticks → o_valid on each tick+1 cycle; o_out_valid=0 for ticks 1–3 and 1 for ticks 4–5; o_par_gain=0 throughout.
- Ramp up: load target=5 with STEP=1, then ticks → o_par_gain 1,2,3,4,5 on successive o_valid edges; o_busy drops with the 5; stays 5 on further ticks.
- Redirect and collision:
  - From gain=8, load target=2 on the same cycle as a tick while the old target is 10 → that tick gives 9; following ticks give 8,7,…,2.
  - Then load 255 with STEP=300 → next tick gives 255, clamped with no overshoot.
- Mute cycle: at gain=4 assert i_mute → 3,2,1,0, then o_muted=1; ticks keep producing o_valid; drop i_mute → 1,2,3,4 and IDLE.
- Reset mid-ramp: at gain=3 ramping to 10, pulse rst=0 for 1 cycle → all outputs zero next edge; target=0; no further gain change on subsequent ticks.
- Fast ramp (GAIN_SEQ_FAST_RAMP_EN, STEP=1): load target=40 from 0 → gains 16,32,33,…,40.

Source files
------------

// File: rtl/effects_gain_sequencer.sv
// Sample-synchronous gain sequencer for the effects pipeline: tick-to-valid strobe,
// zipper-free gain ramping, soft mute and pipeline priming. Optional macro: GAIN_SEQ_FAST_RAMP_EN.
module effects_gain_sequencer #(
  parameter int unsigned GAIN_W    = 11,
  parameter int unsigned STEP      = 1,
  parameter int unsigned PIPE_LAT  = 3,
  parameter logic [GAIN_W-1:0] MUTE_GAIN = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sample_tick,
  input  logic [GAIN_W-1:0] i_gain_target,
  input  logic              i_gain_load,
  input  logic              i_mute,
  output logic              o_valid,
  output logic [GAIN_W-1:0] o_par_gain,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic              o_muted
);

  // Step sizes are clamped to the gain range so they fit the GAIN_W+1 difference width.
  localparam int unsigned    GAIN_RANGE = 2 ** GAIN_W;
  localparam int unsigned    STEP_C     = (STEP > GAIN_RANGE) ? GAIN_RANGE : STEP;
  localparam logic [GAIN_W:0] STEP_V    = STEP_C[GAIN_W:0];
`ifdef GAIN_SEQ_FAST_RAMP_EN
  localparam int unsigned    FAST_C     = (16 * STEP > GAIN_RANGE) ? GAIN_RANGE : 16 * STEP;
  localparam logic [GAIN_W:0] FAST_V    = FAST_C[GAIN_W:0];
`endif
  localparam int unsigned    CNT_W      = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(PIPE_LAT);

  typedef enum logic [1:0] {IDLE, RAMP, MUTE_DOWN, MUTED} state_t;

  state_t             state_reg;
  logic [GAIN_W-1:0]  gain_reg, gain_next, target_reg, dest;
  logic [GAIN_W:0]    diff, step_amt;
  logic               up;
  logic [CNT_W-1:0]   prime_cnt_reg;
  logic               valid_reg, out_valid_reg;

  // One step toward the current destination; the mute request selects where that is.
  always_comb begin
    dest = i_mute ? MUTE_GAIN : target_reg;
    up   = (dest >= gain_reg);
    diff = up ? ({1'b0, dest} - {1'b0, gain_reg}) : ({1'b0, gain_reg} - {1'b0, dest});
`ifdef GAIN_SEQ_FAST_RAMP_EN
    step_amt = (diff > FAST_V) ? FAST_V : STEP_V;
`else
    step_amt = STEP_V;
`endif
    if (step_amt > diff)
      step_amt = diff;
    gain_next = up ? GAIN_W'({1'b0, gain_reg} + step_amt)
                   : GAIN_W'({1'b0, gain_reg} - step_amt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      gain_reg      <= '0;
      target_reg    <= '0;
      prime_cnt_reg <= '0;
      valid_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      valid_reg     <= i_sample_tick;
      out_valid_reg <= i_sample_tick && (prime_cnt_reg == LAT_C);
      if (i_gain_load)
        target_reg <= i_gain_target;
      // A tick that coincides with a load still uses the old target held in target_reg.
      if (i_sample_tick) begin
        if (prime_cnt_reg != LAT_C)
          prime_cnt_reg <= prime_cnt_reg + 1'b1;
        gain_reg <= gain_next;
        if (i_mute)
          state_reg <= (gain_next == MUTE_GAIN) ? MUTED : MUTE_DOWN;
        else
          state_reg <= (gain_next == target_reg) ? IDLE : RAMP;
      end
    end
  end

  assign o_valid     = valid_reg;
  assign o_out_valid = out_valid_reg;
  assign o_par_gain  = gain_reg;
  assign o_busy      = (state_reg == RAMP) || (state_reg == MUTE_DOWN);
  assign o_muted     = (state_reg == MUTED);

endmodule

// File: tb/tb_effects_gain_sequencer.sv
// Randomized self-checking bench for effects_gain_sequencer: two instances (STEP=1 and STEP=5
// with a non-zero mute gain) share one stimulus stream and are compared to an arithmetic model.
module tb_effects_gain_sequencer;
  localparam int GW = 11;
  localparam int LAT = 3;
  localparam int STEPS [2] = '{1, 5};
  localparam int MGAIN [2] = '{0, 3};

  logic clk = 1'b0;
  logic rst = 1'b0, tick = 1'b0, load = 1'b0, mute = 1'b0;
  logic [GW-1:0] tgt = '0;

  logic          a_valid, a_out_valid, a_busy, a_muted;
  logic [GW-1:0] a_gain;
  logic          b_valid, b_out_valid, b_busy, b_muted;
  logic [GW-1:0] b_gain;

  always #5 clk = ~clk;

  effects_gain_sequencer #(.GAIN_W(GW), .STEP(1), .PIPE_LAT(LAT), .MUTE_GAIN(11'd0)) u_dut_a (
    .clk(clk), .rst(rst), .i_sample_tick(tick), .i_gain_target(tgt), .i_gain_load(load),
    .i_mute(mute), .o_valid(a_valid), .o_par_gain(a_gain), .o_out_valid(a_out_valid),
    .o_busy(a_busy), .o_muted(a_muted));

  effects_gain_sequencer #(.GAIN_W(GW), .STEP(5), .PIPE_LAT(LAT), .MUTE_GAIN(11'd3)) u_dut_b (
    .clk(clk), .rst(rst), .i_sample_tick(tick), .i_gain_target(tgt), .i_gain_load(load),
    .i_mute(mute), .o_valid(b_valid), .o_par_gain(b_gain), .o_out_valid(b_out_valid),
    .o_busy(b_busy), .o_muted(b_muted));

  // Reference model: plain integers following the sequencing rules.
  int m_gain [2];
  int m_busy [2];
  int m_muted[2];
  int m_target, m_ticks, m_valid, m_outv;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit t, input bit l, input int tg, input bit m);
    int dest, mag, s;
    if (!r) begin
      m_target = 0; m_ticks = 0; m_valid = 0; m_outv = 0;
      for (int k = 0; k < 2; k++) begin
        m_gain[k] = 0; m_busy[k] = 0; m_muted[k] = 0;
      end
    end else begin
      m_valid = t;
      m_outv  = t && (m_ticks >= LAT);
      if (t) begin
        m_ticks++;
        for (int k = 0; k < 2; k++) begin
          dest = m ? MGAIN[k] : m_target;
          mag  = (dest > m_gain[k]) ? dest - m_gain[k] : m_gain[k] - dest;
          s    = STEPS[k];
`ifdef GAIN_SEQ_FAST_RAMP_EN
          if (mag > 16 * STEPS[k]) s = 16 * STEPS[k];
`endif
          if (s > mag) s = mag;
          m_gain[k]  = (dest > m_gain[k]) ? m_gain[k] + s : m_gain[k] - s;
          m_busy[k]  = (m_gain[k] != dest);
          m_muted[k] = m && (m_gain[k] == dest);
        end
      end
      if (l) m_target = tg;
    end
  endtask

  task automatic cycle(input bit r, input bit t, input bit l, input int tg, input bit m);
    @(negedge clk);
    rst = r; tick = t; load = l; tgt = tg[GW-1:0]; mute = m;
    @(posedge clk);
    model_step(r, t, l, tg, m);
    #1;
    check_val("a_valid",     {31'd0, a_valid},     m_valid);
    check_val("a_out_valid", {31'd0, a_out_valid}, m_outv);
    check_val("a_gain",      {21'd0, a_gain},      m_gain[0]);
    check_val("a_busy",      {31'd0, a_busy},      m_busy[0]);
    check_val("a_muted",     {31'd0, a_muted},     m_muted[0]);
    check_val("b_valid",     {31'd0, b_valid},     m_valid);
    check_val("b_out_valid", {31'd0, b_out_valid}, m_outv);
    check_val("b_gain",      {21'd0, b_gain},      m_gain[1]);
    check_val("b_busy",      {31'd0, b_busy},      m_busy[1]);
    check_val("b_muted",     {31'd0, b_muted},     m_muted[1]);
    if (!r || l)
      $display("txn rst=%0b tick=%0b load=%0b tgt=%0d mute=%0b -> a_gain=%0d b_gain=%0d",
               r, t, l, tg, m, a_gain, b_gain);
  endtask

  task automatic ticks(input int n, input bit m);
    for (int i = 0; i < n; i++) begin
      cycle(1, 1, 0, 0, m);
      cycle(1, 0, 0, 0, m);
    end
  endtask

  initial begin : stim
    bit rm;
    int sel, tg;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);

    // Priming: out_valid only from the (PIPE_LAT+1)-th tick, gain stays 0.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0, 0);
      check_val("prime_out_valid", {31'd0, a_out_valid}, (i >= LAT) ? 32'd1 : 32'd0);
      check_val("prime_gain", {21'd0, a_gain}, 32'd0);
      cycle(1, 0, 0, 0, 0);
    end

    // Ramp up to 5, then hold.
    cycle(1, 0, 1, 5, 0);
    ticks(7, 0);
    check_val("ramp_up_end", {21'd0, a_gain}, 32'd5);

    // Redirect on the load/tick collision: 8 -> 9 (old target 10) -> down to 2.
    cycle(1, 0, 1, 10, 0);
    ticks(3, 0);
    cycle(1, 1, 1, 2, 0);
    check_val("collision_old_target", {21'd0, a_gain}, 32'd9);
    ticks(8, 0);
    check_val("redirect_end", {21'd0, a_gain}, 32'd2);

    // Top of range: all-ones target stops without wrapping.
    cycle(1, 0, 1, 2047, 0);
    for (int i = 0; i < 420; i++) cycle(1, 1, 0, 0, 0);
    check_val("top_clamp", {21'd0, b_gain}, 32'd2047);
    cycle(1, 0, 1, 4, 0);
    for (int i = 0; i < 430; i++) cycle(1, 1, 0, 0, 0);
    check_val("back_to_4", {21'd0, a_gain}, 32'd4);

    // Mute down, hold, and ramp back.
    ticks(6, 1);
    check_val("muted_flag", {31'd0, a_muted}, 32'd1);
    ticks(5, 0);
    check_val("unmute_gain", {21'd0, a_gain}, 32'd4);

    // Reset mid-ramp clears everything including the target.
    cycle(1, 0, 1, 10, 0);
    ticks(3, 0);
    cycle(0, 0, 0, 0, 0);
    check_val("rst_gain", {21'd0, a_gain}, 32'd0);
    ticks(3, 0);
    check_val("rst_no_ramp", {21'd0, a_gain}, 32'd0);

    // Ramp to 40 (exercises the fast-step path when enabled).
    cycle(1, 0, 1, 40, 0);
    ticks(42, 0);
    check_val("ramp_40", {21'd0, a_gain}, 32'd40);

    // Randomized phase.
    rm = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49) == 0) rm = ~rm;
      sel = $urandom_range(3);
      case (sel)
        0:       tg = $urandom_range(63);
        1:       tg = 2047;
        2:       tg = 0;
        default: tg = $urandom_range(2047);
      endcase
      cycle(($urandom_range(399) != 0), ($urandom_range(2) == 0), ($urandom_range(11) == 0), tg, rm);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
